pmt_frame_sched: RTL and testbench



---
 rtl/pmt_frame_sched.sv | 207 ++++++++++++++++++++
 tb/tb_pmt_frame_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_frame_sched.sv
// PMT scan-cache frame scheduler: owns the scan window and drains four source FIFOs
// as atomic 4-word frames into one tagged 64-bit stream.
`timescale 1ns / 1ps

module pmt_frame_sched #(
  parameter int unsigned DATA_WID = 64,
  parameter int unsigned FCNT_WID = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pmt_start_en_i,
  input  logic                  pmt_end_en_i,
  input  logic [3:0]            src_empty_i,
  input  logic [3:0]            src_full_i,
  input  logic [4*DATA_WID-1:0] src_dout_i,
  output logic [3:0]            src_rd_o,
  input  logic                  dn_afull_i,
  output logic                  scan_en_o,
  output logic                  out_vld_o,
  output logic [DATA_WID-1:0]   out_data_o,
  output logic [FCNT_WID-1:0]   frame_cnt_o,
  output logic                  ovf_err_o,
  output logic                  align_err_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StDrainWait,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            slot_q, slot_d;
  logic                  start_lvl_q, end_lvl_q;
  logic                  end_pend_q, end_pend_d;
  logic                  scan_en_q, scan_en_d;
  logic [FCNT_WID-1:0]   frame_cnt_q, frame_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  align_q, align_d;
  logic                  done_q, done_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [3:0]            src_rd;

  logic                  rd_vld_q;
  logic [1:0]            rd_slot_q;
  logic                  out_vld_q;
  logic [DATA_WID-1:0]   out_data_q;
  logic [DATA_WID-1:0]   sel_word;
  logic [2:0]            unused_tag;

  logic start_rise, end_rise, frame_ok, pipe_busy;

  assign start_rise = pmt_start_en_i & ~start_lvl_q;
  assign end_rise   = pmt_end_en_i & ~end_lvl_q;
  // A frame may only launch when every source holds a word and downstream has headroom.
  assign frame_ok   = (src_empty_i == 4'h0) & ~dn_afull_i;
  assign pipe_busy  = rd_vld_q | out_vld_q;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    end_pend_d  = end_pend_q;
    scan_en_d   = scan_en_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    align_d     = align_q;
    done_d      = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    src_rd      = 4'h0;

    if ((state_q != StIdle) && (src_full_i != 4'h0)) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d     = StWait;
          scan_en_d   = 1'b1;
          frame_cnt_d = '0;
          ovf_d       = 1'b0;
          align_d     = 1'b0;
          end_pend_d  = 1'b0;
        end
      end
      StWait: begin
        if (end_rise) begin
          scan_en_d  = 1'b0;
          end_pend_d = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = StDrainWait;
        end else if (frame_ok) begin
          slot_d  = 2'd0;
          state_d = StRead;
        end
      end
      StRead: begin
        src_rd = 4'b0001 << slot_q;
        slot_d = slot_q + 2'd1;
        if (end_rise) begin
          end_pend_d = 1'b1;
          scan_en_d  = 1'b0;
        end
        if (slot_q == 2'd3) begin
          frame_cnt_d = frame_cnt_q + FCNT_WID'(1);
          wait_cnt_d  = 4'd0;
          state_d     = (end_pend_q | end_rise) ? StDrainWait : StWait;
        end
      end
      StDrainWait: begin
        if (frame_ok) begin
          slot_d  = 2'd0;
          state_d = StRead;
        end else if (src_empty_i == 4'hF) begin
          state_d = StDone;
        end else if (src_empty_i != 4'h0) begin
          // Partial frame: give late source writes a bounded chance to land.
          if (wait_cnt_q == 4'd15) begin
            state_d = StDone;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (!pipe_busy) begin
          align_d    = align_q | (src_empty_i != 4'hF);
          done_d     = 1'b1;
          end_pend_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      slot_q      <= 2'd0;
      start_lvl_q <= 1'b0;
      end_lvl_q   <= 1'b0;
      end_pend_q  <= 1'b0;
      scan_en_q   <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      align_q     <= 1'b0;
      done_q      <= 1'b0;
      wait_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      start_lvl_q <= pmt_start_en_i;
      end_lvl_q   <= pmt_end_en_i;
      end_pend_q  <= end_pend_d;
      scan_en_q   <= scan_en_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      align_q     <= align_d;
      done_q      <= done_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    sel_word = src_dout_i[DATA_WID-1:0];
    unique case (rd_slot_q)
      2'd0: sel_word = src_dout_i[0*DATA_WID +: DATA_WID];
      2'd1: sel_word = src_dout_i[1*DATA_WID +: DATA_WID];
      2'd2: sel_word = src_dout_i[2*DATA_WID +: DATA_WID];
      2'd3: sel_word = src_dout_i[3*DATA_WID +: DATA_WID];
      default: sel_word = src_dout_i[DATA_WID-1:0];
    endcase
  end

  // Source tag bits are replaced by the valid flag and slot number.
  assign unused_tag = sel_word[DATA_WID-1:DATA_WID-3];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q   <= 1'b0;
      rd_slot_q  <= 2'd0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      rd_vld_q  <= (src_rd != 4'h0);
      rd_slot_q <= slot_q;
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) begin
        out_data_q <= {1'b1, rd_slot_q, sel_word[DATA_WID-4:0]};
      end
    end
  end

  assign src_rd_o    = src_rd;
  assign scan_en_o   = scan_en_q;
  assign out_vld_o   = out_vld_q;
  assign out_data_o  = out_data_q;
  assign frame_cnt_o = frame_cnt_q;
  assign ovf_err_o   = ovf_q;
  assign align_err_o = align_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pmt_frame_sched.sv
// Directed bench for pmt_frame_sched with behavioural source FIFOs and a word log.
`timescale 1ns / 1ps

module tb_pmt_frame_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_en = 1'b0;
  logic         end_en = 1'b0;
  logic [3:0]   src_empty = 4'hF;
  logic [3:0]   src_full = 4'h0;
  logic [255:0] src_dout = '0;
  logic [3:0]   src_rd;
  logic         afull = 1'b0;
  logic         scan_en, out_vld, ovf_err, align_err, done;
  logic [63:0]  out_data;
  logic [31:0]  frame_cnt;

  always #5 clk = ~clk;

  pmt_frame_sched #(
    .DATA_WID(64),
    .FCNT_WID(32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pmt_start_en_i(start_en),
    .pmt_end_en_i  (end_en),
    .src_empty_i   (src_empty),
    .src_full_i    (src_full),
    .src_dout_i    (src_dout),
    .src_rd_o      (src_rd),
    .dn_afull_i    (afull),
    .scan_en_o     (scan_en),
    .out_vld_o     (out_vld),
    .out_data_o    (out_data),
    .frame_cnt_o   (frame_cnt),
    .ovf_err_o     (ovf_err),
    .align_err_o   (align_err),
    .done_o        (done)
  );

  typedef struct {
    logic [63:0] src_word;
    logic [1:0]  slot;
    logic [63:0] exp_out;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] tag_exp[4];
  logic [63:0] q0[$], q1[$], q2[$], q3[$];
  logic [63:0] out_words[$];
  int          out_cyc[$];
  int          rd_cyc[$];
  logic [3:0]  rd_log[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_empty();
    src_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
  endtask

  task automatic push(input int k, input logic [63:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    upd_empty();
  endtask

  task automatic clear_logs();
    out_words.delete();
    out_cyc.delete();
    rd_cyc.delete();
    rd_log.delete();
    done_cnt = 0;
  endtask

  // One clock: FIFOs pop after the edge that saw rd, outputs are logged at the falling edge.
  task automatic tick();
    logic [3:0] rd_s;
    rd_s = src_rd;
    @(posedge clk);
    #1;
    if (rd_s[0] && q0.size() > 0) src_dout[63:0]    = q0.pop_front();
    if (rd_s[1] && q1.size() > 0) src_dout[127:64]  = q1.pop_front();
    if (rd_s[2] && q2.size() > 0) src_dout[191:128] = q2.pop_front();
    if (rd_s[3] && q3.size() > 0) src_dout[255:192] = q3.pop_front();
    upd_empty();
    @(negedge clk);
    cyc++;
    if (out_vld) begin
      out_words.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    if (src_rd != 4'h0) begin
      rd_cyc.push_back(cyc);
      rd_log.push_back(src_rd);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int b;
    b = budget;
    while (out_words.size() < n && b > 0) begin
      tick();
      b--;
    end
    chk(name, 64'(out_words.size()), 64'(n));
  endtask

  task automatic wait_done(input int budget, input string name);
    int b;
    b = budget;
    while (done_cnt == 0 && b > 0) begin
      tick();
      b--;
    end
    chk(name, 64'(done_cnt), 64'd1);
  endtask

  task automatic wait_rd(input logic [3:0] pat, input int budget, input string name);
    int b;
    b = budget;
    while (src_rd != pat && b > 0) begin
      tick();
      b--;
    end
    chk(name, 64'(src_rd), 64'(pat));
  endtask

  task automatic pulse_start();
    start_en = 1'b1;
    tick();
    start_en = 1'b0;
    tick();
  endtask

  task automatic pulse_end();
    end_en = 1'b1;
    tick();
    end_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{64'hFFFF_0000_0000_0000, 2'd0, 64'h9FFF_0000_0000_0000};
    vecs[1]  = '{64'hFFFF_0000_0000_0001, 2'd1, 64'hBFFF_0000_0000_0001};
    vecs[2]  = '{64'hFFFF_0000_0000_0002, 2'd2, 64'hDFFF_0000_0000_0002};
    vecs[3]  = '{64'hFFFF_0000_0000_0003, 2'd3, 64'hFFFF_0000_0000_0003};
    vecs[4]  = '{64'h1FFF_0000_0000_0010, 2'd0, 64'h9FFF_0000_0000_0010};
    vecs[5]  = '{64'h1FFF_0000_0000_0011, 2'd1, 64'hBFFF_0000_0000_0011};
    vecs[6]  = '{64'h1FFF_0000_0000_0012, 2'd2, 64'hDFFF_0000_0000_0012};
    vecs[7]  = '{64'h1FFF_0000_0000_0013, 2'd3, 64'hFFFF_0000_0000_0013};
    vecs[8]  = '{64'h7FFF_0000_0000_0020, 2'd0, 64'h9FFF_0000_0000_0020};
    vecs[9]  = '{64'h7FFF_0000_0000_0021, 2'd1, 64'hBFFF_0000_0000_0021};
    vecs[10] = '{64'h7FFF_0000_0000_0022, 2'd2, 64'hDFFF_0000_0000_0022};
    vecs[11] = '{64'h7FFF_0000_0000_0023, 2'd3, 64'hFFFF_0000_0000_0023};
    tag_exp[0] = 64'h8000_0000_0000_0000;
    tag_exp[1] = 64'hA000_0000_0000_0000;
    tag_exp[2] = 64'hC000_0000_0000_0000;
    tag_exp[3] = 64'hE000_0000_0000_0000;

    // Reset state
    ticks(3);
    chk("rst_scan_en", 64'(scan_en), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_errs", 64'({ovf_err, align_err, done}), 64'd0);
    chk("rst_src_rd", 64'(src_rd), 64'd0);
    rst = 1'b0;
    tick();

    // Three preloaded frames, tag rewrite and fixed latency
    for (int i = 0; i < 12; i++) push(int'(vecs[i].slot), vecs[i].src_word);
    pulse_start();
    chk("s1_scan_en", 64'(scan_en), 64'd1);
    wait_words(12, 60, "s1_word_count");
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("s1_word%0d", i), (i < out_words.size()) ? out_words[i] : 64'hx,
          vecs[i].exp_out);
      chk($sformatf("s1_rd%0d", i), (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hx,
          64'(4'b0001 << (i % 4)));
    end
    if (out_cyc.size() >= 12) begin
      for (int f = 0; f < 3; f++) begin
        for (int j = 1; j < 4; j++) begin
          chk($sformatf("s1_contig_f%0d_w%0d", f, j),
              64'(out_cyc[4*f+j] - out_cyc[4*f]), 64'(j));
        end
      end
    end
    chk("s1_latency", 64'(out_cyc[0] - rd_cyc[0]), 64'd2);
    ticks(2);
    chk("s1_frame_cnt", 64'(frame_cnt), 64'd3);

    // One source empty holds the frame back until it fills
    clear_logs();
    push(0, 64'h0); push(1, 64'h0); push(3, 64'h0);
    ticks(6);
    chk("s2_no_rd", 64'(rd_log.size()), 64'd0);
    push(2, 64'h0);
    wait_rd(4'b0001, 2, "s2_start_within_2");
    wait_words(4, 20, "s2_word_count");
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("s2_word%0d", j), (j < out_words.size()) ? out_words[j] : 64'hx,
          tag_exp[j]);
    end
    ticks(1);
    chk("s2_frame_cnt", 64'(frame_cnt), 64'd4);

    // Almost-full mid-frame: frame completes, next one is held off
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(k, 64'h5);
      push(k, 64'h6);
    end
    wait_rd(4'b0010, 20, "s3_reach_slot1");
    afull = 1'b1;
    ticks(12);
    chk("s3_words_held", 64'(out_words.size()), 64'd4);
    chk("s3_rds_held", 64'(rd_log.size()), 64'd4);
    chk("s3_frame_cnt_held", 64'(frame_cnt), 64'd5);
    afull = 1'b0;
    wait_words(8, 30, "s3_resume_words");
    ticks(1);
    chk("s3_frame_cnt", 64'(frame_cnt), 64'd6);

    // End during slot 2 with two frames queued behind
    clear_logs();
    for (int k = 0; k < 4; k++) for (int n = 0; n < 3; n++) push(k, 64'(n));
    wait_rd(4'b0100, 20, "s4_reach_slot2");
    pulse_end();
    chk("s4_scan_en_off", 64'(scan_en), 64'd0);
    wait_done(100, "s4_done");
    ticks(3);
    chk("s4_done_once", 64'(done_cnt), 64'd1);
    chk("s4_words", 64'(out_words.size()), 64'd12);
    chk("s4_frame_cnt", 64'(frame_cnt), 64'd9);
    chk("s4_align", 64'(align_err), 64'd0);
    chk("s4_done_after_data", 64'(done_cyc > out_cyc[out_cyc.size()-1]), 64'd1);

    // Leftover word on source 0 at end of drain
    clear_logs();
    pulse_start();
    chk("s5_frame_cnt_clr", 64'(frame_cnt), 64'd0);
    chk("s5_scan_en", 64'(scan_en), 64'd1);
    for (int k = 0; k < 4; k++) push(k, 64'h9);
    push(0, 64'hA);
    wait_words(4, 20, "s5_words");
    ticks(1);
    chk("s5_frame_cnt", 64'(frame_cnt), 64'd1);
    pulse_end();
    wait_done(60, "s5_done");
    ticks(2);
    chk("s5_done_once", 64'(done_cnt), 64'd1);
    chk("s5_align", 64'(align_err), 64'd1);
    chk("s5_leftover", 64'(q0.size()), 64'd1);

    // Overflow flag: ignored in IDLE, sticky in scan, cleared by start
    clear_logs();
    src_full = 4'b0010;
    tick();
    src_full = 4'b0000;
    chk("s6_ovf_idle", 64'(ovf_err), 64'd0);
    pulse_start();
    chk("s6_align_clr", 64'(align_err), 64'd0);
    src_full = 4'b0010;
    tick();
    src_full = 4'b0000;
    chk("s6_ovf_set", 64'(ovf_err), 64'd1);
    ticks(5);
    chk("s6_ovf_sticky", 64'(ovf_err), 64'd1);
    pulse_end();
    wait_done(60, "s6_done");
    chk("s6_ovf_after_done", 64'(ovf_err), 64'd1);
    pulse_start();
    chk("s6_ovf_clr", 64'(ovf_err), 64'd0);

    // Reset in the middle of a frame
    src_full = 4'b0001;
    tick();
    src_full = 4'b0000;
    push(1, 64'h1); push(2, 64'h2); push(3, 64'h3);
    wait_rd(4'b0010, 10, "s7_reach_slot1");
    rst = 1'b1;
    tick();
    chk("s7_src_rd", 64'(src_rd), 64'd0);
    chk("s7_scan_en", 64'(scan_en), 64'd0);
    chk("s7_out_vld", 64'(out_vld), 64'd0);
    chk("s7_out_data", out_data, 64'd0);
    chk("s7_errs", 64'({ovf_err, align_err, done}), 64'd0);
    chk("s7_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    upd_empty();
    clear_logs();
    for (int k = 0; k < 4; k++) push(k, 64'h7);
    ticks(6);
    chk("s7_idle_no_rd", 64'(rd_log.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
